// File: rtl/gt_vortex_dma_rd_arb.sv
// Two-requester arbiter for a shared DMA read channel: alternating priority on ties,
// one transaction owns the DMA from grant until its final data beat.
module gt_vortex_dma_rd_arb #(
  parameter int unsigned RESET_PRIO = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  rq_ctrl_valid,
  output logic [1:0]  rq_ctrl_ready,
  input  logic [63:0] rq_ctrl_data_index,
  input  logic [63:0] rq_ctrl_data_length,
  input  logic [5:0]  rq_ctrl_data_size,
  output logic [1:0]  rq_chnl_valid,
  input  logic [1:0]  rq_chnl_ready,
  output logic [63:0] rq_chnl_data,
  output logic        dma_read_ctrl_valid,
  input  logic        dma_read_ctrl_ready,
  output logic [31:0] dma_read_ctrl_data_index,
  output logic [31:0] dma_read_ctrl_data_length,
  output logic [2:0]  dma_read_ctrl_data_size,
  input  logic        dma_read_chnl_valid,
  output logic        dma_read_chnl_ready,
  input  logic [63:0] dma_read_chnl_data,
  output logic [1:0]  owner
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CTRL,
    S_DATA
  } state_t;

  // Pointer resets to the loser so RESET_PRIO takes the first tie.
  localparam logic LAST_RST = (RESET_PRIO == 0) ? 1'b1 : 1'b0;

  state_t      r_state;
  logic [1:0]  r_owner;
  logic        r_last;
  logic [31:0] r_idx;
  logic [31:0] r_len;
  logic [2:0]  r_size;
  logic [31:0] r_cnt;

  logic        w_any;
  logic        w_win;
  logic        w_zero_len;
  logic        w_beat;
  logic [31:0] w_idx;
  logic [31:0] w_len;
  logic [2:0]  w_size;

  always_comb begin
    w_any = |rq_ctrl_valid;
    if (&rq_ctrl_valid) w_win = ~r_last;
    else                w_win = rq_ctrl_valid[1];
    w_idx  = w_win ? rq_ctrl_data_index[63:32]  : rq_ctrl_data_index[31:0];
    w_len  = w_win ? rq_ctrl_data_length[63:32] : rq_ctrl_data_length[31:0];
    w_size = w_win ? rq_ctrl_data_size[5:3]     : rq_ctrl_data_size[2:0];
    w_zero_len = (r_len == '0);
  end

  // Handshake steering is combinational on top of the registered state/owner.
  always_comb begin
    dma_read_ctrl_valid       = (r_state == S_CTRL) && !w_zero_len;
    dma_read_ctrl_data_index  = r_idx;
    dma_read_ctrl_data_length = r_len;
    dma_read_ctrl_data_size   = r_size;
    rq_ctrl_ready             = '0;
    if (r_state == S_CTRL && (w_zero_len || dma_read_ctrl_ready))
      rq_ctrl_ready = r_owner;
    rq_chnl_valid       = '0;
    dma_read_chnl_ready = 1'b0;
    if (r_state == S_DATA) begin
      rq_chnl_valid       = dma_read_chnl_valid ? r_owner : 2'b00;
      dma_read_chnl_ready = |(r_owner & rq_chnl_ready);
    end
    rq_chnl_data = dma_read_chnl_data;
    owner        = r_owner;
    w_beat       = (r_state == S_DATA) && dma_read_chnl_valid && dma_read_chnl_ready;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_owner <= '0;
      r_last  <= LAST_RST;
      r_idx   <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state <= S_CTRL;
            r_owner <= w_win ? 2'b10 : 2'b01;
            r_last  <= w_win;
            r_idx   <= w_idx;
            r_len   <= w_len;
            r_size  <= w_size;
          end
        end
        S_CTRL: begin
          if (w_zero_len) begin
            r_state <= S_IDLE;
            r_owner <= '0;
          end else if (dma_read_ctrl_ready) begin
            r_cnt   <= r_len;
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_beat) begin
            r_cnt <= r_cnt - 32'd1;
            if (r_cnt == 32'd1) begin
              r_state <= S_IDLE;
              r_owner <= '0;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_owner <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gt_vortex_dma_rd_arb.sv
// Directed bench for gt_vortex_dma_rd_arb: grant order, zero-length, backpressure,
// async reset mid-transaction and control-stall field stability.
module tb_gt_vortex_dma_rd_arb;

  logic        clk;
  logic        rst;
  logic [1:0]  rq_ctrl_valid;
  logic [1:0]  rq_ctrl_ready;
  logic [63:0] rq_ctrl_data_index;
  logic [63:0] rq_ctrl_data_length;
  logic [5:0]  rq_ctrl_data_size;
  logic [1:0]  rq_chnl_valid;
  logic [1:0]  rq_chnl_ready;
  logic [63:0] rq_chnl_data;
  logic        dma_read_ctrl_valid;
  logic        dma_read_ctrl_ready;
  logic [31:0] dma_read_ctrl_data_index;
  logic [31:0] dma_read_ctrl_data_length;
  logic [2:0]  dma_read_ctrl_data_size;
  logic        dma_read_chnl_valid;
  logic        dma_read_chnl_ready;
  logic [63:0] dma_read_chnl_data;
  logic [1:0]  owner;

  int checks = 0;
  int errors = 0;

  gt_vortex_dma_rd_arb #(.RESET_PRIO(0)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .rq_ctrl_valid             (rq_ctrl_valid),
    .rq_ctrl_ready             (rq_ctrl_ready),
    .rq_ctrl_data_index        (rq_ctrl_data_index),
    .rq_ctrl_data_length       (rq_ctrl_data_length),
    .rq_ctrl_data_size         (rq_ctrl_data_size),
    .rq_chnl_valid             (rq_chnl_valid),
    .rq_chnl_ready             (rq_chnl_ready),
    .rq_chnl_data              (rq_chnl_data),
    .dma_read_ctrl_valid       (dma_read_ctrl_valid),
    .dma_read_ctrl_ready       (dma_read_ctrl_ready),
    .dma_read_ctrl_data_index  (dma_read_ctrl_data_index),
    .dma_read_ctrl_data_length (dma_read_ctrl_data_length),
    .dma_read_ctrl_data_size   (dma_read_ctrl_data_size),
    .dma_read_chnl_valid       (dma_read_chnl_valid),
    .dma_read_chnl_ready       (dma_read_chnl_ready),
    .dma_read_chnl_data        (dma_read_chnl_data),
    .owner                     (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    rq_ctrl_valid       = '0;
    rq_ctrl_data_index  = '0;
    rq_ctrl_data_length = '0;
    rq_ctrl_data_size   = '0;
    rq_chnl_ready       = '0;
    dma_read_ctrl_ready = 1'b0;
    dma_read_chnl_valid = 1'b0;
    dma_read_chnl_data  = '0;
  endtask

  task automatic do_reset;
    clear_inputs();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset;
    clear_inputs();
    rst = 1'b0;
    #3;
    checks++; if (owner !== 2'b00) begin errors++; $display("FAIL reset_owner got %b exp 00", owner); end
    checks++; if (rq_ctrl_ready !== 2'b00) begin errors++; $display("FAIL reset_rq_ctrl_ready got %b exp 00", rq_ctrl_ready); end
    checks++; if (dma_read_ctrl_valid !== 1'b0) begin errors++; $display("FAIL reset_ctrl_valid got %b exp 0", dma_read_ctrl_valid); end
    checks++; if (rq_chnl_valid !== 2'b00 || dma_read_chnl_ready !== 1'b0) begin
      errors++; $display("FAIL reset_chnl got valid %b ready %b exp 00/0", rq_chnl_valid, dma_read_chnl_ready); end
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic test_single;
    do_reset();
    rq_ctrl_valid = 2'b01;
    rq_ctrl_data_index[31:0]  = 32'h100;
    rq_ctrl_data_length[31:0] = 32'd4;
    rq_ctrl_data_size[2:0]    = 3'd3;
    dma_read_ctrl_ready = 1'b1;
    #1;
    checks++; if (rq_ctrl_ready !== 2'b00 || dma_read_ctrl_valid !== 1'b0) begin
      errors++; $display("FAIL single_idle got rdy %b val %b exp 00/0", rq_ctrl_ready, dma_read_ctrl_valid); end
    step();
    checks++; if (dma_read_ctrl_valid !== 1'b1) begin errors++; $display("FAIL single_ctrl_valid got %b exp 1", dma_read_ctrl_valid); end
    checks++; if (dma_read_ctrl_data_index !== 32'h100 || dma_read_ctrl_data_length !== 32'd4 || dma_read_ctrl_data_size !== 3'd3) begin
      errors++; $display("FAIL single_fields got %h/%0d/%0d exp 100/4/3", dma_read_ctrl_data_index, dma_read_ctrl_data_length, dma_read_ctrl_data_size); end
    checks++; if (rq_ctrl_ready !== 2'b01 || owner !== 2'b01) begin
      errors++; $display("FAIL single_grant got rdy %b owner %b exp 01/01", rq_ctrl_ready, owner); end
    rq_ctrl_valid = 2'b00;
    step();
    checks++; if (rq_ctrl_ready !== 2'b00 || dma_read_ctrl_valid !== 1'b0 || owner !== 2'b01) begin
      errors++; $display("FAIL single_data_entry got rdy %b val %b owner %b exp 00/0/01", rq_ctrl_ready, dma_read_ctrl_valid, owner); end
    dma_read_chnl_valid = 1'b1;
    rq_chnl_ready = 2'b01;
    for (int i = 0; i < 4; i++) begin
      dma_read_chnl_data = 64'hD0 + 64'(i);
      #1;
      checks++; if (rq_chnl_valid !== 2'b01 || dma_read_chnl_ready !== 1'b1 || rq_chnl_data !== 64'hD0 + 64'(i) || owner !== 2'b01) begin
        errors++; $display("FAIL single_beat%0d got v %b r %b d %h o %b exp 01/1/%h/01", i, rq_chnl_valid, dma_read_chnl_ready, rq_chnl_data, owner, 64'hD0 + 64'(i)); end
      step();
    end
    checks++; if (owner !== 2'b00 || rq_chnl_valid !== 2'b00 || dma_read_chnl_ready !== 1'b0) begin
      errors++; $display("FAIL single_done got o %b v %b r %b exp 00/00/0", owner, rq_chnl_valid, dma_read_chnl_ready); end
    clear_inputs();
  endtask

  task automatic test_tie;
    logic [1:0]  exp_own  [9] = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01};
    logic        exp_ctrl [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] exp_idx  [9] = '{32'hA0, 0, 0, 0, 32'hB0, 0, 0, 0, 32'hA0};
    do_reset();
    rq_ctrl_valid       = 2'b11;
    rq_ctrl_data_index  = {32'hB0, 32'hA0};
    rq_ctrl_data_length = {32'd2, 32'd2};
    dma_read_ctrl_ready = 1'b1;
    dma_read_chnl_valid = 1'b1;
    rq_chnl_ready       = 2'b11;
    for (int e = 0; e < 9; e++) begin
      step();
      checks++; if (owner !== exp_own[e]) begin errors++; $display("FAIL tie_owner_e%0d got %b exp %b", e, owner, exp_own[e]); end
      if (exp_ctrl[e]) begin
        checks++; if (dma_read_ctrl_valid !== 1'b1 || dma_read_ctrl_data_index !== exp_idx[e]) begin
          errors++; $display("FAIL tie_ctrl_e%0d got v %b idx %h exp 1/%h", e, dma_read_ctrl_valid, dma_read_ctrl_data_index, exp_idx[e]); end
      end
      if (exp_own[e] == 2'b00) begin
        checks++; if (rq_ctrl_ready !== 2'b00) begin errors++; $display("FAIL tie_idle_held_e%0d got %b exp 00", e, rq_ctrl_ready); end
      end
    end
    clear_inputs();
  endtask

  task automatic test_zero_len;
    do_reset();
    rq_ctrl_valid = 2'b01;
    rq_ctrl_data_length = '0;
    step();
    checks++; if (rq_ctrl_ready !== 2'b01 || dma_read_ctrl_valid !== 1'b0 || owner !== 2'b01) begin
      errors++; $display("FAIL zlen_pulse got rdy %b val %b o %b exp 01/0/01", rq_ctrl_ready, dma_read_ctrl_valid, owner); end
    rq_ctrl_valid = 2'b00;
    step();
    checks++; if (rq_ctrl_ready !== 2'b00 || dma_read_ctrl_valid !== 1'b0 || owner !== 2'b00) begin
      errors++; $display("FAIL zlen_idle got rdy %b val %b o %b exp 00/0/00", rq_ctrl_ready, dma_read_ctrl_valid, owner); end
    rq_ctrl_valid = 2'b11;
    rq_ctrl_data_length = {32'd1, 32'd1};
    step();
    checks++; if (owner !== 2'b10) begin errors++; $display("FAIL zlen_pointer got %b exp 10", owner); end
    clear_inputs();
  endtask

  task automatic test_backpressure;
    logic [4:0] pat = 5'b10101;
    int beats = 0;
    do_reset();
    rq_ctrl_valid = 2'b10;
    rq_ctrl_data_index[63:32]  = 32'h300;
    rq_ctrl_data_length[63:32] = 32'd3;
    dma_read_ctrl_ready = 1'b1;
    step();
    checks++; if (owner !== 2'b10 || dma_read_ctrl_data_index !== 32'h300) begin
      errors++; $display("FAIL bp_grant got o %b idx %h exp 10/300", owner, dma_read_ctrl_data_index); end
    rq_ctrl_valid = 2'b00;
    step();
    dma_read_chnl_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rq_chnl_ready = {pat[i], 1'b1};
      #1;
      checks++; if (dma_read_chnl_ready !== pat[i] || rq_chnl_valid !== 2'b10 || owner !== 2'b10) begin
        errors++; $display("FAIL bp_cycle%0d got r %b v %b o %b exp %b/10/10", i, dma_read_chnl_ready, rq_chnl_valid, owner, pat[i]); end
      if (rq_chnl_valid[1] && dma_read_chnl_ready) beats++;
      step();
    end
    checks++; if (beats != 3) begin errors++; $display("FAIL bp_beats got %0d exp 3", beats); end
    checks++; if (owner !== 2'b00 || rq_chnl_valid !== 2'b00) begin
      errors++; $display("FAIL bp_done got o %b v %b exp 00/00", owner, rq_chnl_valid); end
    clear_inputs();
  endtask

  task automatic test_reset_mid;
    do_reset();
    rq_ctrl_valid = 2'b01;
    rq_ctrl_data_length[31:0] = 32'd5;
    dma_read_ctrl_ready = 1'b1;
    step();
    rq_ctrl_valid = 2'b00;
    step();
    dma_read_chnl_valid = 1'b1;
    rq_chnl_ready = 2'b11;
    step();
    step();
    #1;
    checks++; if (rq_chnl_valid !== 2'b01) begin errors++; $display("FAIL rmid_pre got %b exp 01", rq_chnl_valid); end
    rst = 1'b0;
    #1;
    checks++; if (owner !== 2'b00 || rq_chnl_valid !== 2'b00 || dma_read_chnl_ready !== 1'b0 || rq_ctrl_ready !== 2'b00 || dma_read_ctrl_valid !== 1'b0) begin
      errors++; $display("FAIL rmid_async got o %b v %b r %b cr %b cv %b exp all 0", owner, rq_chnl_valid, dma_read_chnl_ready, rq_ctrl_ready, dma_read_ctrl_valid); end
    step();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (rq_chnl_valid !== 2'b00 || dma_read_chnl_ready !== 1'b0 || owner !== 2'b00) begin
        errors++; $display("FAIL rmid_after%0d got v %b r %b o %b exp 00/0/00", i, rq_chnl_valid, dma_read_chnl_ready, owner); end
    end
    clear_inputs();
  endtask

  task automatic test_ctrl_stall;
    do_reset();
    rq_ctrl_valid = 2'b01;
    rq_ctrl_data_index[31:0]  = 32'h500;
    rq_ctrl_data_length[31:0] = 32'd2;
    rq_ctrl_data_size[2:0]    = 3'd1;
    step();
    for (int i = 0; i < 10; i++) begin
      rq_ctrl_data_index[31:0] = 32'h600 + 32'(i);
      #1;
      checks++; if (dma_read_ctrl_data_index !== 32'h500 || rq_ctrl_ready !== 2'b00 || dma_read_ctrl_valid !== 1'b1) begin
        errors++; $display("FAIL stall%0d got idx %h rdy %b v %b exp 500/00/1", i, dma_read_ctrl_data_index, rq_ctrl_ready, dma_read_ctrl_valid); end
      step();
    end
    dma_read_ctrl_ready = 1'b1;
    #1;
    checks++; if (rq_ctrl_ready !== 2'b01) begin errors++; $display("FAIL stall_release got %b exp 01", rq_ctrl_ready); end
    clear_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    clear_inputs();
    test_reset();
    test_single();
    test_tie();
    test_zero_len();
    test_backpressure();
    test_reset_mid();
    test_ctrl_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gt_vortex_dma_rd_arb.md
GT_VORTEX_DMA_RD_ARB -- requirements
Module: gt_vortex_dma_rd_arb

Interface
REQ-001 Parameter: RESET_PRIO, default 0, index of the requester that wins the first simultaneous request after reset.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 rq_ctrl_valid  in  2  per-requester read-ctrl request, bit n = requester n.
REQ-005 rq_ctrl_ready  out  2  per-requester ctrl accept.
REQ-006 rq_ctrl_data_index  in  64  {idx1,idx0}, 32 bits each.
REQ-007 rq_ctrl_data_length  in  64  {len1,len0}, beats, 32 bits each.
REQ-008 rq_ctrl_data_size  in  6  {size1,size0}, 3 bits each.
REQ-009 rq_chnl_valid  out  2  data-beat valid to the owning requester only.
REQ-010 rq_chnl_ready  in  2  per-requester data ready.
REQ-011 rq_chnl_data  out  64  data broadcast, qualified by rq_chnl_valid.
REQ-012 dma_read_ctrl_valid / _ready  out / in  1 / 1  shared DMA read-ctrl handshake.
REQ-013 dma_read_ctrl_data_index / _length / _size  out  32 / 32 / 3  forwarded request fields.
REQ-014 dma_read_chnl_valid / _ready / _data  in / out / in  1 / 1 / 64  shared DMA read data.
REQ-015 owner  out  2  one-hot current owner; 00 when idle.

Function
REQ-016 States: IDLE, CTRL, DATA; one transaction owns the DMA from grant until its last beat.
REQ-017 IDLE: if any rq_ctrl_valid, grant one requester: single request wins; both request -> the requester not granted last (after reset: RESET_PRIO); go to CTRL next cycle.
REQ-018 On grant, latch index, length and size of the winner into registers; owner set to winner's one-hot.
REQ-019 CTRL: dma_read_ctrl_valid=1 with the latched fields; rq_ctrl_ready[owner] asserted combinationally equal to dma_read_ctrl_ready; all other rq_ctrl_ready bits 0.
REQ-020 CTRL exits on dma_read_ctrl_valid & dma_read_ctrl_ready; beat counter loads latched length; go to DATA.
REQ-021 Length 0 at grant: rq_ctrl_ready[owner] pulses 1 cycle in the grant-following cycle, no DMA request issued, return to IDLE, last-grant pointer updated.
REQ-022 DATA: rq_chnl_valid[owner]=dma_read_chnl_valid; dma_read_chnl_ready=rq_chnl_ready[owner]; rq_chnl_data=dma_read_chnl_data; non-owner valid 0.
REQ-023 Each DATA-state beat handshake decrements the 32-bit counter; handshake when counter==1 -> IDLE, owner=00 next cycle.
REQ-024 Outside DATA, dma_read_chnl_ready=0 and rq_chnl_valid=00.
REQ-025 Requests arriving during CTRL/DATA are held (not acked) and arbitrated in IDLE; a grant needs at least 1 IDLE cycle between transactions.
REQ-026 Requester dropping rq_ctrl_valid after grant does not abort the transaction.
REQ-027 Latched fields are stable throughout CTRL regardless of rq_ctrl_data_* changes.

Reset
REQ-028 rst low asynchronously forces IDLE, owner=00, counter=0, all valid/ready outputs 0, last-grant pointer = RESET_PRIO's complement (so RESET_PRIO wins first tie).
REQ-029 Reset mid-transaction discards it; no beats forwarded after rst deasserts until a new grant.

Verification
REQ-030 Only req0 valid, idx0=0x100, len0=4, size0=3; DMA ready -> dma ctrl shows 0x100/4/3, rq_ctrl_ready=01 for 1 cycle, 4 beats to requester 0, owner 01 then 00.
REQ-031 Both valid at once after reset, RESET_PRIO=0, len 2 each -> req0 served first, then req1 after 1 IDLE cycle; third tie -> req0 again.
REQ-032 len0=0 -> rq_ctrl_ready[0] pulses once, dma_read_ctrl_valid never asserts, owner returns to 00.
REQ-033 len1=3, rq_chnl_ready[1] toggles 1,0,1,0,1 with DMA valid held -> exactly 3 beats counted, dma_read_chnl_ready mirrors rq_chnl_ready[1].
REQ-034 rst asserted after 2 of 5 beats -> all outputs 0 immediately, owner 00; following beats not forwarded.
REQ-035 dma_read_ctrl_ready held low 10 cycles while rq_ctrl_data_index changes -> forwarded index stays at latched value, rq_ctrl_ready stays 00.
